// File: rtl/debounce_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debounce_multi                                               |
// | Description : Multi-channel pushbutton/switch debouncer. A shared          |
// |               prescaler produces a sample tick; each channel has a         |
// |               two-flop synchroniser, a 4-state filter FSM, a registered    |
// |               debounced level and registered one-cycle rise/fall pulses.   |
// | Options     : define DEBOUNCE_REPEAT_EN to add per-channel auto-repeat     |
// |               pulses on btn_rise while a channel is held high.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module debounce_multi #(
   parameter int CHANNELS     = 4,
   parameter int DIV_BITS     = 16,
   parameter int STABLE_TICKS = 4,
   parameter int REPEAT_TICKS = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] btn_db,
   output logic [CHANNELS-1:0] btn_rise,
   output logic [CHANNELS-1:0] btn_fall,
   output logic                tick
);

   // Stable counter must be able to hold STABLE_TICKS itself.
   localparam int                 c_CNT_W       = $clog2(STABLE_TICKS + 1);
   localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(STABLE_TICKS);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

   // Filter FSM encoding: debounced level is high in STABLE_HI and PEND_LO.
   localparam logic [1:0] c_STABLE_LO = 2'd0;
   localparam logic [1:0] c_PEND_HI   = 2'd1;
   localparam logic [1:0] c_STABLE_HI = 2'd2;
   localparam logic [1:0] c_PEND_LO   = 2'd3;

`ifdef DEBOUNCE_REPEAT_EN
   localparam int                 c_REP_W       = $clog2(REPEAT_TICKS + 1);
   localparam logic [c_REP_W-1:0] c_REPEAT_LAST = c_REP_W'(REPEAT_TICKS);
   localparam logic [c_REP_W-1:0] c_REP_ONE     = c_REP_W'(1);
`endif

   // Reject nonsensical configurations at elaboration time.
   if (CHANNELS < 1 || DIV_BITS < 1 || STABLE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
      $error("debounce_multi: all parameters must be >= 1");
   end

   logic [DIV_BITS-1:0] r_presc;
   logic                r_tick;
   logic [CHANNELS-1:0] r_sync1;
   logic [CHANNELS-1:0] r_sync2;

   // Free-running prescaler; tick is registered one cycle after the counter is all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_presc <= r_presc + DIV_BITS'(1);
         r_tick  <= &r_presc;
      end
   end

   assign tick = r_tick;

   // Two-flop synchroniser for the raw asynchronous inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic [1:0]         r_state;
      logic [1:0]         w_state_next;
      logic [c_CNT_W-1:0] r_cnt;
      logic [c_CNT_W-1:0] w_cnt_next;
      logic [c_CNT_W-1:0] w_cnt_inc;
      logic               r_db;
      logic               r_rise;
      logic               r_fall;
      logic               w_db_next;
      logic               w_rise_next;
      logic               w_fall_next;
      logic               w_sample;
      logic               w_rep_pulse;

      assign w_sample  = r_sync2[ch];
      assign w_cnt_inc = r_cnt + c_CNT_ONE;

      // Filter state and agreeing-sample counter.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_state <= c_STABLE_LO;
            r_cnt   <= '0;
         end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
         end
      end

      // Next state: the filter only moves on sample ticks and holds otherwise.
      always_comb begin
         w_state_next = r_state;
         w_cnt_next   = r_cnt;
         if (r_tick) begin
            case (r_state)
               c_STABLE_LO: begin
                  if (w_sample) begin
                     if (STABLE_TICKS == 1) begin
                        w_state_next = c_STABLE_HI;
                        w_cnt_next   = '0;
                     end else begin
                        w_state_next = c_PEND_HI;
                        w_cnt_next   = c_CNT_ONE;
                     end
                  end
               end
               c_PEND_HI: begin
                  if (w_sample) begin
                     if (w_cnt_inc == c_STABLE_LAST) begin
                        w_state_next = c_STABLE_HI;
                        w_cnt_next   = '0;
                     end else begin
                        w_cnt_next   = w_cnt_inc;
                     end
                  end else begin
                     w_state_next = c_STABLE_LO;
                     w_cnt_next   = '0;
                  end
               end
               c_STABLE_HI: begin
                  if (!w_sample) begin
                     if (STABLE_TICKS == 1) begin
                        w_state_next = c_STABLE_LO;
                        w_cnt_next   = '0;
                     end else begin
                        w_state_next = c_PEND_LO;
                        w_cnt_next   = c_CNT_ONE;
                     end
                  end
               end
               c_PEND_LO: begin
                  if (!w_sample) begin
                     if (w_cnt_inc == c_STABLE_LAST) begin
                        w_state_next = c_STABLE_LO;
                        w_cnt_next   = '0;
                     end else begin
                        w_cnt_next   = w_cnt_inc;
                     end
                  end else begin
                     w_state_next = c_STABLE_HI;
                     w_cnt_next   = '0;
                  end
               end
               default: begin
                  w_state_next = c_STABLE_LO;
                  w_cnt_next   = '0;
               end
            endcase
         end
      end

`ifdef DEBOUNCE_REPEAT_EN
      logic [c_REP_W-1:0] r_rep;
      logic [c_REP_W-1:0] w_rep_inc;
      logic               w_rep_hold;

      assign w_rep_inc   = r_rep + c_REP_ONE;
      assign w_rep_hold  = r_tick && r_db && w_db_next;
      assign w_rep_pulse = w_rep_hold && (w_rep_inc == c_REPEAT_LAST);

      // Repeat counter: counts ticks spent high, cleared on entry, exit and after each repeat.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_rep <= '0;
         end else if (r_tick) begin
            if (w_rep_hold && !w_rep_pulse) begin
               r_rep <= w_rep_inc;
            end else begin
               r_rep <= '0;
            end
         end
      end
`else
      assign w_rep_pulse = 1'b0;
`endif

      // Output decode: level follows the next state, edges compare it with the current level.
      always_comb begin
         w_db_next   = (w_state_next == c_STABLE_HI) || (w_state_next == c_PEND_LO);
         w_rise_next = (w_db_next & ~r_db) | w_rep_pulse;
         w_fall_next = ~w_db_next & r_db;
      end

      // Registered level and one-cycle edge pulses, updated on the transition edge.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_db   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
         end else begin
            r_db   <= w_db_next;
            r_rise <= w_rise_next;
            r_fall <= w_fall_next;
         end
      end

      assign btn_db[ch]   = r_db;
      assign btn_rise[ch] = r_rise;
      assign btn_fall[ch] = r_fall;
   end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_debounce_multi                                            |
// | Description : Directed self-checking bench for debounce_multi with         |
// |               DIV_BITS=2 (tick every 4 cycles), STABLE_TICKS=3, 4 channels.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_debounce_multi;

   localparam int CHANNELS     = 4;
   localparam int DIV_BITS     = 2;
   localparam int STABLE_TICKS = 3;
   localparam int REPEAT_TICKS = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [CHANNELS-1:0] btn_in = '0;
   logic [CHANNELS-1:0] btn_db;
   logic [CHANNELS-1:0] btn_rise;
   logic [CHANNELS-1:0] btn_fall;
   logic                tick;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;
   int n_rise;
   int n_fall;
   int first_rise;

   debounce_multi #(
      .CHANNELS     (CHANNELS),
      .DIV_BITS     (DIV_BITS),
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .btn_db   (btn_db),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   // Cycle index since reset release: after the k-th edge cyc == k.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance to just after an edge whose index modulo 4 equals p.
   task automatic wait_phase(input int p);
      do step(); while ((cyc % 4) != p);
   endtask

   // Step n cycles; level is db0 before step t and db1 from step t on, with
   // rise/fall pulses exactly at step t. Tick is checked every cycle.
   task automatic expect_window(input string tag, input int n, input logic [3:0] db0,
                                input logic [3:0] db1, input int t);
      logic [3:0] e_db;
      logic [3:0] e_rise;
      logic [3:0] e_fall;
      for (int i = 1; i <= n; i++) begin
         step();
         e_db   = (i >= t) ? db1 : db0;
         e_rise = (i == t) ? (db1 & ~db0) : 4'b0000;
         e_fall = (i == t) ? (db0 & ~db1) : 4'b0000;
         check({tag, "_db"},   btn_db,   e_db);
         check({tag, "_rise"}, btn_rise, e_rise);
         check({tag, "_fall"}, btn_fall, e_fall);
         check({tag, "_tick"}, tick,     (cyc % 4) == 0);
      end
   endtask

   initial begin
      // Reset state.
      #12;
      check("rst_tick", tick,     1'b0);
      check("rst_db",   btn_db,   4'b0000);
      check("rst_rise", btn_rise, 4'b0000);
      check("rst_fall", btn_fall, 4'b0000);
      #10;
      rst = 1'b0;

      // Idle: tick every 4th cycle, everything else quiet.
      expect_window("idle", 40, 4'b0000, 4'b0000, 0);

      // Clean press and release on ch0, launched one cycle after a tick.
      wait_phase(1);
      btn_in[0] = 1'b1;
      expect_window("ch0_press", 60, 4'b0000, 4'b0001, 12);
      wait_phase(1);
      btn_in[0] = 1'b0;
      expect_window("ch0_release", 20, 4'b0001, 4'b0000, 12);

      // 5-cycle high glitch on ch1 seen by exactly one tick.
      wait_phase(1);
      btn_in[1] = 1'b1;
      expect_window("ch1_glitch_hi", 5, 4'b0000, 4'b0000, 0);
      btn_in[1] = 1'b0;
      expect_window("ch1_glitch_hi_after", 25, 4'b0000, 4'b0000, 0);

      // ch1 pressed, then a 1-cycle low glitch that a tick does sample.
      wait_phase(1);
      btn_in[1] = 1'b1;
      expect_window("ch1_press", 20, 4'b0000, 4'b0010, 12);
      wait_phase(2);
      btn_in[1] = 1'b0;
      expect_window("ch1_glitch_lo", 1, 4'b0010, 4'b0010, 0);
      btn_in[1] = 1'b1;
      expect_window("ch1_glitch_lo_after", 20, 4'b0010, 4'b0010, 0);
      wait_phase(1);
      btn_in[1] = 1'b0;
      expect_window("ch1_release", 20, 4'b0010, 4'b0000, 12);

      // Bouncing press on ch2: toggle every 3 cycles, then hold high.
      wait_phase(1);
      n_rise = 0;
      n_fall = 0;
      for (int i = 0; i < 70; i++) begin
         btn_in[2] = (i < 30) ? (((i / 3) % 2) == 0) : 1'b1;
         step();
         n_rise += int'(btn_rise[2]);
         n_fall += int'(btn_fall[2]);
         if (i == 29) check("bounce_press_early_rise", n_rise, 0);
      end
      check("bounce_press_rises", n_rise, 1);
      check("bounce_press_falls", n_fall, 0);
      check("bounce_press_db", btn_db, 4'b0100);

      // Bouncing release on ch2, then hold low.
      n_rise = 0;
      n_fall = 0;
      for (int i = 0; i < 70; i++) begin
         btn_in[2] = (i < 30) ? (((i / 3) % 2) != 0) : 1'b0;
         step();
         n_rise += int'(btn_rise[2]);
         n_fall += int'(btn_fall[2]);
         if (i == 29) check("bounce_release_early_fall", n_fall, 0);
      end
      check("bounce_release_rises", n_rise, 0);
      check("bounce_release_falls", n_fall, 1);
      check("bounce_release_db", btn_db, 4'b0000);

      // ch0 and ch3 change together.
      wait_phase(1);
      btn_in = 4'b1001;
      expect_window("ch03_press", 20, 4'b0000, 4'b1001, 12);
      wait_phase(1);
      btn_in = 4'b0000;
      expect_window("ch03_release", 20, 4'b1001, 4'b0000, 12);

      // ch3 high, ch1 caught in PEND_HI, then reset pulsed.
      wait_phase(1);
      btn_in[3] = 1'b1;
      expect_window("ch3_press", 20, 4'b0000, 4'b1000, 12);
      wait_phase(1);
      btn_in[1] = 1'b1;
      expect_window("ch1_pend", 6, 4'b1000, 4'b1000, 0);
      rst = 1'b1;
      #1;
      check("midrst_db",   btn_db,   4'b0000);
      check("midrst_rise", btn_rise, 4'b0000);
      check("midrst_fall", btn_fall, 4'b0000);
      check("midrst_tick", tick,     1'b0);
      step();
      check("midrst_db_held",   btn_db,   4'b0000);
      check("midrst_fall_held", btn_fall, 4'b0000);
      rst = 1'b0;
      // Both inputs held through reset: fresh count from STABLE_LO, rise at edge 13.
      expect_window("post_rst", 20, 4'b0000, 4'b1010, 13);
      wait_phase(1);
      btn_in = 4'b0000;
      expect_window("post_rst_release", 20, 4'b1010, 4'b0000, 12);

      // Long hold on ch0: count rise pulses.
      wait_phase(1);
      btn_in[0] = 1'b1;
      n_rise = 0;
      first_rise = 0;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (btn_rise[0]) begin
            n_rise++;
            if (first_rise == 0) first_rise = i;
         end
      end
      check("hold_first_rise", first_rise, 12);
`ifdef DEBOUNCE_REPEAT_EN
      check("hold_rise_count", n_rise, 6);
`else
      check("hold_rise_count", n_rise, 1);
`endif
      check("hold_db", btn_db, 4'b0001);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
